// File: rtl/oled_text_sequencer_if.sv
// ----------------------------------------------------------------------------
// oled_text_sequencer_if
// Groups every non-clock/reset signal of the OLED text sequencer.
//   slave  : the sequencer itself (owns the buffer, drives grants and the
//            sendData/sendDataValid side of the controller handshake).
//   master : the environment, i.e. the two write requesters, the clear
//            source and the OLED controller (drives sendDone).
// Signals:
//   wr_req_a/b, wr_addr_a/b, wr_char_a/b : write requests into the buffer
//   wr_gnt_a/b                           : one-cycle "write performed" pulses
//   clear_req                            : one-cycle "blank the buffer" pulse
//   send_data, send_data_valid           : character stream to the controller
//   send_done                            : controller acknowledge (level)
//   busy, frame_done                     : status
// ----------------------------------------------------------------------------
interface oled_text_sequencer_if #(
   parameter int ADDR_W = 6
);
   logic              wr_req_a;
   logic [ADDR_W-1:0] wr_addr_a;
   logic [6:0]        wr_char_a;
   logic              wr_gnt_a;
   logic              wr_req_b;
   logic [ADDR_W-1:0] wr_addr_b;
   logic [6:0]        wr_char_b;
   logic              wr_gnt_b;
   logic              clear_req;
   logic [6:0]        send_data;
   logic              send_data_valid;
   logic              send_done;
   logic              busy;
   logic              frame_done;

   modport master (
      output wr_req_a, wr_addr_a, wr_char_a,
      input  wr_gnt_a,
      output wr_req_b, wr_addr_b, wr_char_b,
      input  wr_gnt_b,
      output clear_req,
      input  send_data, send_data_valid,
      output send_done,
      input  busy, frame_done
   );

   modport slave (
      input  wr_req_a, wr_addr_a, wr_char_a,
      output wr_gnt_a,
      input  wr_req_b, wr_addr_b, wr_char_b,
      output wr_gnt_b,
      input  clear_req,
      output send_data, send_data_valid,
      input  send_done,
      output busy, frame_done
   );
endinterface

// File: rtl/oled_text_sequencer.sv
// ----------------------------------------------------------------------------
// oled_text_sequencer
// Owns the NUM_CHARS-cell character buffer of the OLED text path, arbitrates
// writes from two requesters into it, and streams the whole buffer in linear
// order to the OLED controller whenever it has changed. After reset, or on a
// clear request, every cell is first overwritten with BLANK_CHAR.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high reset
//   bus   : oled_text_sequencer_if.slave (requesters, clear, controller
//           handshake, status)
// ----------------------------------------------------------------------------
module oled_text_sequencer #(
   parameter int         NUM_CHARS  = 64,
   parameter int         ADDR_W     = 6,
   parameter logic [6:0] BLANK_CHAR = 7'h20
) (
   input logic                  clock,
   input logic                  reset,
   oled_text_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_SEND,
      S_WAIT_DONE,
      S_WAIT_RELEASE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CHARS - 1);
   localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic              RR_A     = 1'b0;
   localparam logic              RR_B     = 1'b1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              dirty_q, dirty_d;
   logic              clr_pend_q, clr_pend_d;
   logic              rr_last_q, rr_last_d;
   logic              gnt_a_q, gnt_a_d;
   logic              gnt_b_q, gnt_b_d;
   logic [6:0]        send_data_q, send_data_d;
   logic              send_valid_q, send_valid_d;
   logic              frame_done_q, frame_done_d;
   logic              frame_end_q, frame_end_d;

   // Single write port shared by the clear sweep and the arbiter; the two
   // never use it in the same cycle because the arbiter is off in CLEAR.
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [6:0]        mem_wdata;
   logic [6:0]        buf_mem [NUM_CHARS];

   logic              elig_a;
   logic              elig_b;

   always_comb begin
      state_d      = state_q;
      clr_idx_d    = clr_idx_q;
      idx_d        = idx_q;
      dirty_d      = dirty_q;
      clr_pend_d   = clr_pend_q;
      rr_last_d    = rr_last_q;
      gnt_a_d      = 1'b0;
      gnt_b_d      = 1'b0;
      send_data_d  = send_data_q;
      send_valid_d = send_valid_q;
      frame_done_d = 1'b0;
      frame_end_d  = frame_end_q;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;

      // A requester whose grant is showing is still holding the old request;
      // ignoring it this cycle prevents the same write landing twice.
      elig_a = bus.wr_req_a && !gnt_a_q;
      elig_b = bus.wr_req_b && !gnt_b_q;

      unique case (state_q)
         S_CLEAR: begin
            mem_we    = 1'b1;
            mem_addr  = clr_idx_q;
            mem_wdata = BLANK_CHAR;
            clr_idx_d = clr_idx_q + IDX_ONE;
            if (clr_idx_q == LAST_IDX) begin
               dirty_d = 1'b1;
               state_d = S_IDLE;
            end
         end

         S_IDLE: begin
            if (clr_pend_q || bus.clear_req) begin
               clr_pend_d = 1'b0;
               clr_idx_d  = '0;
               state_d    = S_CLEAR;
            end else if (dirty_q) begin
               idx_d   = '0;
               dirty_d = 1'b0;
               state_d = S_SEND;
            end
         end

         // The cell is captured here, so later writes to it cannot disturb
         // the character already presented to the controller.
         S_SEND: begin
            send_data_d  = buf_mem[idx_q];
            send_valid_d = 1'b1;
            state_d      = S_WAIT_DONE;
         end

         S_WAIT_DONE: begin
            if (bus.send_done) begin
               send_valid_d = 1'b0;
               state_d      = S_WAIT_RELEASE;
               if (idx_q == LAST_IDX) begin
                  frame_done_d = 1'b1;
                  frame_end_d  = 1'b1;
               end else begin
                  idx_d       = idx_q + IDX_ONE;
                  frame_end_d = 1'b0;
               end
            end
         end

         // Waiting for sendDone to fall gives exactly one advance per
         // acknowledge, however long the controller holds it.
         S_WAIT_RELEASE: begin
            if (!bus.send_done) begin
               state_d = frame_end_q ? S_IDLE : S_SEND;
            end
         end

         default: begin
            state_d = S_CLEAR;
         end
      endcase

      // A clear during a frame is deferred so the frame is never truncated
      // and the controller's column/page counters stay aligned.
      if (bus.clear_req &&
          (state_q == S_SEND || state_q == S_WAIT_DONE || state_q == S_WAIT_RELEASE)) begin
         clr_pend_d = 1'b1;
      end

      // Evaluated after the FSM so a write on the IDLE->SEND edge re-sets
      // dirty and schedules another frame.
      if (state_q != S_CLEAR) begin
         if (elig_a && (!elig_b || rr_last_q == RR_B)) begin
            mem_we    = 1'b1;
            mem_addr  = bus.wr_addr_a;
            mem_wdata = bus.wr_char_a;
            gnt_a_d   = 1'b1;
            dirty_d   = 1'b1;
            if (elig_b) begin
               rr_last_d = RR_A;
            end
         end else if (elig_b) begin
            mem_we    = 1'b1;
            mem_addr  = bus.wr_addr_b;
            mem_wdata = bus.wr_char_b;
            gnt_b_d   = 1'b1;
            dirty_d   = 1'b1;
            if (elig_a) begin
               rr_last_d = RR_B;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_CLEAR;
         clr_idx_q    <= '0;
         idx_q        <= '0;
         dirty_q      <= 1'b1;
         clr_pend_q   <= 1'b0;
         rr_last_q    <= RR_B;
         gnt_a_q      <= 1'b0;
         gnt_b_q      <= 1'b0;
         send_data_q  <= '0;
         send_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         frame_end_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_idx_q    <= clr_idx_d;
         idx_q        <= idx_d;
         dirty_q      <= dirty_d;
         clr_pend_q   <= clr_pend_d;
         rr_last_q    <= rr_last_d;
         gnt_a_q      <= gnt_a_d;
         gnt_b_q      <= gnt_b_d;
         send_data_q  <= send_data_d;
         send_valid_q <= send_valid_d;
         frame_done_q <= frame_done_d;
         frame_end_q  <= frame_end_d;
      end
   end

   // Buffer storage has no reset; the clear sweep initialises it.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         buf_mem[mem_addr] <= mem_wdata;
      end
   end

   assign bus.wr_gnt_a        = gnt_a_q;
   assign bus.wr_gnt_b        = gnt_b_q;
   assign bus.send_data       = send_data_q;
   assign bus.send_data_valid = send_valid_q;
   assign bus.frame_done      = frame_done_q;
   assign bus.busy            = (state_q != S_IDLE);

endmodule
